led_blink_scheduler: RTL and testbench

Controller that shares the single board LED between NUM_REQ requesters. Each requester asks for a burst of N blinks. The scheduler arbitrates between requests and sequences the LED on/off phases on the tick_enable strobe from enable_generator. It then inserts an inter-burst gap and signals completion. It sits between enable_generator and the LED pin and replaces the free-running led_blinker wherever status codes must be flashed.

---
 rtl/led_sched_pkg.sv | 23 ++
 rtl/led_req_arbiter.sv | 70 +++++++
 rtl/led_blink_scheduler.sv | 149 ++++++++++++++
 tb/tb_led_blink_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED blink scheduler.
//   state_e        : scheduler FSM states (3-bit encoding)
//   Def*           : default values for NUM_REQ / CNT_W / GAP_TICKS
//   gap_cnt_width  : width of the gap counter, $clog2(GAP_TICKS+1) with a floor of 1
package led_sched_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StOn   = 3'd2,
    StOff  = 3'd3,
    StGap  = 3'd4
  } state_e;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefCntW     = 4;
  localparam int unsigned DefGapTicks = 2;

  function automatic int unsigned gap_cnt_width(int unsigned gap_ticks);
    return (gap_ticks < 2) ? 1 : $clog2(gap_ticks + 1);
  endfunction

endpackage

// File: rtl/led_req_arbiter.sv
// Request arbiter for the LED blink scheduler.
// Build option: LED_SCHED_RR_EN
//   defined   : round-robin; search starts at the pointer, which moves to winner+1 on accept
//   undefined : fixed priority, lowest index wins (purely combinational; a busy low index
//               can starve higher ones)
// Ports:
//   clk, rst    : clock and asynchronous active-high reset (pointer only)
//   req         : request vector
//   accept      : winner is being captured this cycle
//   winner      : one-hot winner (zero when no request)
//   winner_idx  : binary index of the winner
//   valid       : at least one request is pending
module led_req_arbiter
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

`ifdef LED_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [31:0]      scan_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept && valid) begin
      ptr_q <= (winner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

  always_comb begin
    valid      = 1'b0;
    winner_idx = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!valid && req[scan_idx[IDX_W-1:0]]) begin
        valid      = 1'b1;
        winner_idx = scan_idx[IDX_W-1:0];
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, accept};

  always_comb begin
    valid      = 1'b0;
    winner_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[IDX_W'(i)]) begin
        valid      = 1'b1;
        winner_idx = IDX_W'(i);
      end
    end
  end
`endif

  assign winner = valid ? (NUM_REQ'(1) << winner_idx) : '0;

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one board LED between NUM_REQ requesters. A captured requester gets a burst of
// req_count blinks (one tick_enable period on, one off), followed by GAP_TICKS ticks of
// LED-off gap, then a single-cycle done pulse.
// Build option: LED_SCHED_RR_EN selects round-robin arbitration (fixed priority otherwise).
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   tick_enable      : one-cycle strobe, one strobe per LED half-period
//   req              : request levels, sampled only while idle
//   req_count        : blink count of requester i at [i*CNT_W +: CNT_W]
//   grant            : one-hot, requester being served
//   done             : one-cycle pulse at end of burst + gap
//   busy             : high whenever the scheduler is not idle
//   led              : registered LED drive, active-high
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned GAP_TICKS = DefGapTicks
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     tick_enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     done,
  output logic                     busy,
  output logic                     led
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW = gap_cnt_width(GAP_TICKS);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_TICKS);

  state_e             state_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [GapW-1:0]    gap_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               done_q;
  logic               busy_q;
  logic               led_q;

  logic               accept;
  logic               finish;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IdxW-1:0]    win_idx;
  logic               win_valid;
  logic [CNT_W-1:0]   win_count;

  // No capture during the done cycle, so the next arbitration is at least one cycle later.
  assign accept = (state_q == StIdle) && !done_q && win_valid;

  led_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_arbiter (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .req        (req),
    .accept     (accept),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  assign win_count = req_count[32'(win_idx) * CNT_W +: CNT_W];

  // Completion: last OFF tick when there is no gap, or the final gap tick. A zero gap count in
  // GAP (zero-count burst with GAP_TICKS=0) completes without waiting for a tick.
  assign finish =
      ((state_q == StOff) && tick_enable && (remaining_q <= CNT_W'(1)) && (GAP_TICKS == 0)) ||
      ((state_q == StGap) && ((gap_q == '0) || (tick_enable && (gap_q == GapW'(1)))));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      gap_q       <= '0;
      grant_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      led_q       <= 1'b0;
    end else if (finish) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      gap_q       <= '0;
      grant_q     <= '0;
      done_q      <= 1'b1;
      busy_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            grant_q     <= win_onehot;
            busy_q      <= 1'b1;
            remaining_q <= win_count;
            if (win_count == '0) begin
              gap_q   <= GapLoad;
              state_q <= StGap;
            end else begin
              state_q <= StArm;
            end
          end
        end
        // Waiting here aligns the first ON phase to a tick so it lasts a full period.
        StArm: begin
          if (tick_enable) begin
            led_q   <= 1'b1;
            state_q <= StOn;
          end
        end
        StOn: begin
          if (tick_enable) begin
            led_q   <= 1'b0;
            state_q <= StOff;
          end
        end
        StOff: begin
          if (tick_enable) begin
            if (remaining_q > CNT_W'(1)) begin
              remaining_q <= remaining_q - 1'b1;
              led_q       <= 1'b1;
              state_q     <= StOn;
            end else begin
              remaining_q <= '0;
              gap_q       <= GapLoad;
              state_q     <= StGap;
            end
          end
        end
        StGap: begin
          if (tick_enable && (gap_q != '0)) begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler. A burst-level model predicts outputs from the number of
// ticks seen since capture; every cycle the main DUT (GAP_TICKS=2) is compared against it.
// A second instance with GAP_TICKS=0 is checked by hand for the zero-count case.
module tb_led_blink_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;
  localparam int GAP     = 2;

  logic                     sys_clk = 1'b0;
  logic                     sys_rst;
  logic                     tick_enable;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       grant, grant0;
  logic                     done, busy, led;
  logic                     done0, busy0, led0;

  int n_vec = 0;
  int n_err = 0;

  // Model state: burst-level view
  logic               m_busy, m_done, m_led;
  logic [NUM_REQ-1:0] m_grant;
  int                 m_n, m_k, m_ptr;
  int                 tphase = 0;

  always #5 sys_clk = ~sys_clk;

  led_blink_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .CNT_W     (CNT_W),
    .GAP_TICKS (GAP)
  ) u_dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .tick_enable (tick_enable),
    .req         (req),
    .req_count   (req_count),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .led         (led)
  );

  led_blink_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .CNT_W     (CNT_W),
    .GAP_TICKS (0)
  ) u_dut_gap0 (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .tick_enable (tick_enable),
    .req         (req),
    .req_count   (req_count),
    .grant       (grant0),
    .done        (done0),
    .busy        (busy0),
    .led         (led0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_led   = 1'b0;
    m_grant = '0;
    m_n     = 0;
    m_k     = 0;
    m_ptr   = 0;
  endtask

  // Burst of N: ticks k=1..2N alternate ON/OFF (k=1 leaves ARM), gap follows, done on tick
  // 2N+GAP+1. Zero count: gap only, done on tick GAP, or next cycle when GAP=0.
  task automatic model_step();
    int   tgt;
    int   w;
    int   j;
    logic was_done;
    if (sys_rst) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (tick_enable) m_k++;
      tgt = (m_n == 0) ? GAP : 2 * m_n + GAP + 1;
      if (tgt == 0 || m_k == tgt) begin
        m_busy  = 1'b0;
        m_grant = '0;
        m_done  = 1'b1;
        m_led   = 1'b0;
      end else begin
        m_led = (m_k % 2 == 1) && (m_k <= 2 * m_n);
      end
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (!was_done && req != '0) begin
        w = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef LED_SCHED_RR_EN
          j = (m_ptr + i) % NUM_REQ;
`else
          j = i;
`endif
          if (w < 0 && req[j]) w = j;
        end
        m_n     = int'((req_count >> (w * CNT_W)) & ((1 << CNT_W) - 1));
        m_k     = 0;
        m_busy  = 1'b1;
        m_grant = NUM_REQ'(1 << w);
        m_ptr   = (w + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic compare_model();
    check("led", led, m_led);
    check("grant", grant, m_grant);
    check("done", done, m_done);
    check("busy", busy, m_busy);
  endtask

  task automatic cyc(input logic tk);
    tick_enable = tk;
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare_model();
  endtask

  // One cycle with a tick every third cycle.
  task automatic pcyc();
    tphase = (tphase + 1) % 3;
    cyc(tphase == 0);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((m_busy || m_done || busy0 || done0) && i < 300) begin
      pcyc();
      i++;
    end
    check("idle_bound", (i < 300), 1);
    pcyc();
    pcyc();
  endtask

  task automatic run_burst(output int ticks, output int pulses, output int on_cyc,
                           output logic seen);
    logic prev;
    prev   = 1'b0;
    ticks  = 0;
    pulses = 0;
    on_cyc = 0;
    seen   = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      pcyc();
      if (tick_enable) ticks++;
      if (led) on_cyc++;
      if (led && !prev) pulses++;
      prev = led;
      if (done) begin
        seen = 1'b1;
        check("grant_at_done", grant, 4'b0000);
        check("busy_at_done", busy, 1'b0);
      end
    end
  endtask

  initial begin
    int               ticks, pulses, on_cyc;
    logic             seen;
    logic [NUM_REQ-1:0] g [3];
    int               ng;
    logic [NUM_REQ-1:0] prev_g;
    logic             any_done;

    model_reset();
    sys_rst     = 1'b1;
    tick_enable = 1'b0;
    req         = '0;
    req_count   = '0;
    cyc(0);
    cyc(0);
    check("rst_led", led, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    sys_rst = 1'b0;
    pcyc();
    pcyc();

    // Single request, count 3
    req_count = 16'h0003;
    req       = 4'b0001;
    cyc(0);
    check("t1_grant", grant, 4'b0001);
    check("t1_led_at_capture", led, 0);
    req = '0;
    run_burst(ticks, pulses, on_cyc, seen);
    check("t1_done_seen", seen, 1);
    check("t1_pulses", pulses, 3);
    check("t1_ticks", ticks, 9);
    check("t1_on_cycles", on_cyc, 9);
    wait_idle();

    // Zero count on requester 2
    req_count = 16'h50A5;
    req       = 4'b0100;
    cyc(0);
    check("t2_grant", grant, 4'b0100);
    check("t2_grant_gap0", grant0, 4'b0100);
    req = '0;
    cyc(0);
    check("t2_done_gap0", done0, 1);
    check("t2_grant_gap0_clr", grant0, 4'b0000);
    check("t2_led_gap0", led0, 0);
    run_burst(ticks, pulses, on_cyc, seen);
    check("t2_done_seen", seen, 1);
    check("t2_ticks", ticks, 2);
    check("t2_pulses", pulses, 0);
    wait_idle();

    // Request dropped and count changed after capture
    req_count = 16'h0002;
    req       = 4'b0001;
    cyc(0);
    check("t3_grant", grant, 4'b0001);
    req       = '0;
    req_count = 16'hFFFF;
    run_burst(ticks, pulses, on_cyc, seen);
    check("t3_done_seen", seen, 1);
    check("t3_pulses", pulses, 2);
    check("t3_ticks", ticks, 7);
    wait_idle();

    // Tick in the capture cycle is ignored; first ON phase is a full period
    req_count = 16'h0001;
    req       = 4'b0001;
    tphase    = 0;
    cyc(1);
    check("t4_grant", grant, 4'b0001);
    check("t4_led_cap", led, 0);
    req = '0;
    pcyc();
    check("t4_led_w1", led, 0);
    pcyc();
    check("t4_led_w2", led, 0);
    pcyc();
    check("t4_led_on", led, 1);
    pcyc();
    pcyc();
    check("t4_led_hold", led, 1);
    pcyc();
    check("t4_led_off", led, 0);
    wait_idle();

    // Asynchronous reset during an ON phase
    req_count = 16'h0003;
    req       = 4'b0001;
    cyc(0);
    req = '0;
    for (int i = 0; i < 20 && !led; i++) pcyc();
    check("t5_led_before_rst", led, 1);
    #2 sys_rst = 1'b1;
    #1;
    check("t5_rst_led", led, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_busy", busy, 0);
    model_reset();
    cyc(0);
    sys_rst  = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pcyc();
      if (done) any_done = 1'b1;
    end
    check("t5_no_spurious_done", any_done, 0);

    // Arbitration with requesters 1 and 3 held
    req_count = 16'h1111;
    req       = 4'b1010;
    ng        = 0;
    prev_g    = '0;
    for (int i = 0; i < 200 && ng < 3; i++) begin
      pcyc();
      if (grant != '0 && prev_g == '0) begin
        g[ng] = grant;
        ng++;
      end
      prev_g = grant;
    end
    req = '0;
    check("t6_grants_seen", ng, 3);
`ifdef LED_SCHED_RR_EN
    check("t6_g0", g[0], 4'b0010);
    check("t6_g1", g[1], 4'b1000);
    check("t6_g2", g[2], 4'b0010);
`else
    check("t6_g0", g[0], 4'b0010);
    check("t6_g1", g[1], 4'b0010);
    check("t6_g2", g[2], 4'b0010);
`endif
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
